serial_div: RTL and testbench
=============================

# serial_div

Signed bit-serial divider, the inverse companion of `serial_mul` in the serial arithmetic library. It computes a truncating quotient and a remainder of two two's-complement operands using one restoring-division step per clock. It uses the same `start`/`data_ready` handshake as the multiplier, so both can share one sequencer in the datapath.

## Interface
- `N_BITS_A`, default 8: dividend and quotient width (signed).
- `N_BITS_B`, default 8: divisor and remainder width (signed).

- `clk  in  1`: single clock; all state changes on its rising edge.
- `reset  in  1`: asynchronous, active-low reset. One clock domain; polarity and asynchronous behaviour are fixed.
- `a  in  N_BITS_A`: dividend, signed; sampled only on the start edge.
- `b  in  N_BITS_B`: divisor, signed; sampled only on the start edge.
- `start  in  1`: request; accepted only in IDLE.
- `busy  out  1`: high from the accepting edge until the result edge.
- `data_ready  out  1`: one-cycle pulse when results are valid.
- `quotient  out  N_BITS_A`: signed quotient; held until the next result edge.
- `remainder  out  N_BITS_B`: signed remainder; held until the next result edge.
- `div_by_zero  out  1`: flag for the current result; held with the result.
- `overflow  out  1`: flag for the current result; held with the result.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - When `start` = 1 at an edge, latch `sa = a[msb]`, `sb = b[msb]`.
  - Latch `|a|` into an N_BITS_A-bit unsigned shift register and `|b|` into an N_BITS_B-bit unsigned register. |−2^(N−1)| fits unsigned.
  - Clear the partial remainder (N_BITS_B+1 bits) and the step counter, set `busy`, go to CALC.
- **CALC**, one step per edge:
  - Shift `{prem, dividend_sr}` left by one.
  - Trial subtract |b|. If non-negative, keep the difference and shift in 1; otherwise restore and shift in 0.
  - After N_BITS_A steps, go to FIX.
- **FIX**
  - Quotient sign = `sa ^ sb`; remainder sign = `sa`. Negate the magnitudes as needed.
  - Truncate to output widths and register the outputs and flags.
  - Pulse `data_ready`, clear `busy`, go to IDLE.
- Rounding: truncation toward zero. Invariant: `a == q*b + r` and `|r| < |b|`.
- Divide by zero (`b == 0` at start):
  - Latency is unchanged.
  - `quotient` = 0, `remainder` = `a` truncated/sign-extended to N_BITS_B, `div_by_zero` = 1.
- Overflow: `a == −2^(N_BITS_A−1)` and `b == −1` gives `quotient` = −2^(N_BITS_A−1) (two's-complement wrap), `remainder` = 0, `overflow` = 1.
- `start` while `busy` is ignored; the operation in flight is not disturbed.
- `start` in the cycle `data_ready` is high is accepted, because the FSM is already in IDLE.
- Reset, at any time including mid-CALC, immediately forces:
  - state IDLE;
  - `busy`, `data_ready`, `quotient`, `remainder`, `div_by_zero`, `overflow` all 0;
  - internal registers 0.

## Timing
- Start accepted at edge k. CALC steps occur on edges k+1 … k+N_BITS_A. FIX runs at edge k+N_BITS_A+1.
- After edge k+N_BITS_A+1: `data_ready` = 1 and outputs are valid.
- After edge k+N_BITS_A+2: `data_ready` = 0; outputs stay unchanged.
- Total latency is N_BITS_A+1 edges; for 8 bits that is 9, matching the multiplier's worst case.
- `busy` is high after edges k … k+N_BITS_A and low after the FIX edge.
- Back-to-back throughput: one result every N_BITS_A+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `serial_div_pkg`:
  - `typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t`
  - helper `function` for a width-generic step-counter bit count (`$clog2(N_BITS_A+1)`).
- Sub-module `div_sign_fix`: purely combinational. Takes the unsigned magnitudes plus `sa`, `sb`, `b_zero`, `ovf` and produces the signed `quotient`/`remainder`/flags. Used in FIX and unit-testable alone.
- Top level holds the FSM, shift registers, counter and output registers.

## Test plan
- Use 8/8 for all cases. `a` = 100, `b` = 7, start at edge k -> `data_ready` pulse after edge k+9 only; `quotient` = 14, `remainder` = 2.
- Sign cases, each with both flags 0:
  - −100/7 -> q = −14, r = −2
  - 100/−7 -> q = −14, r = 2
  - −100/−7 -> q = 14, r = −2
- Boundary cases:
  - −128/−1 -> q = −128, r = 0, `overflow` = 1
  - 5/0 -> q = 0, r = 5, `div_by_zero` = 1
  - −128/1 -> q = −128, `overflow` = 0
- Handshake:
  - `start` pulsed with 3/1 at edge k+4 of an active 100/7 -> ignored; result stays 14/2.
  - `start` during the `data_ready` cycle -> next result follows 9 edges later.
- Reset: drop `reset` at edge k+5 of 100/7 -> all outputs 0 and `busy` 0 immediately. After release, 50/6 -> q = 8, r = 2.
- Exhaustive sweep: a, b ∈ [−128, 127] compared against the reference model (truncating division plus the zero/overflow rules). Log to `simout.txt` in the multiplier bench format, with zero mismatches required.

Source files
------------

// File: rtl/serial_div_pkg.sv
// Shared types and helpers for the signed bit-serial divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

    // Bits needed for a step counter that must hold values 0..n_bits.
    function automatic int cnt_bits(input int n_bits);
        return $clog2(n_bits + 1);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Converts unsigned quotient/remainder magnitudes into signed results and flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   q_mag, r_mag   unsigned magnitudes from the restoring-division core
//   sa, sb         sign bits of the original dividend / divisor
//   b_zero, ovf    divide-by-zero and most-negative/-1 conditions seen at start
//   quotient, remainder, div_by_zero, overflow   signed results and flags
module div_sign_fix #(
    parameter int N_BITS_A = 8,
    parameter int N_BITS_B = 8
) (
    input  logic [N_BITS_A-1:0] q_mag,
    input  logic [N_BITS_B-1:0] r_mag,
    input  logic                sa,
    input  logic                sb,
    input  logic                b_zero,
    input  logic                ovf,
    output logic [N_BITS_A-1:0] quotient,
    output logic [N_BITS_B-1:0] remainder,
    output logic                div_by_zero,
    output logic                overflow
);

    always_comb begin
        quotient    = '0;
        remainder   = '0;
        div_by_zero = b_zero;
        overflow    = ovf & ~b_zero;

        // Divide by zero: the core never subtracts anything, so r_mag ends up
        // holding the low bits of |a|; re-applying the dividend sign gives back
        // a truncated/sign-extended to the remainder width.
        if (!b_zero) begin
            quotient = (sa ^ sb) ? (~q_mag + 1'b1) : q_mag;
        end
        remainder = sa ? (~r_mag + 1'b1) : r_mag;
        // Overflow needs no special case: |q| = 2^(N-1) wraps to the most
        // negative value on truncation, and the remainder is naturally 0.
    end

endmodule

// File: rtl/serial_div.sv
// Signed restoring bit-serial divider, truncating toward zero, one step per clock.
// Latency: N_BITS_A+1 edges from the accepting start edge to the data_ready pulse.
// Backpressure: none; start is ignored while busy, results held until the next result.
//
// Ports:
//   clk, reset (async, active-low)
//   a, b, start                       operands and request (sampled when idle)
//   busy, data_ready                  in-flight flag and one-cycle result pulse
//   quotient, remainder, div_by_zero, overflow   registered results
module serial_div
    import serial_div_pkg::*;
#(
    parameter int N_BITS_A = 8,
    parameter int N_BITS_B = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_BITS_A-1:0] a,
    input  logic [N_BITS_B-1:0] b,
    input  logic                start,
    output logic                busy,
    output logic                data_ready,
    output logic [N_BITS_A-1:0] quotient,
    output logic [N_BITS_B-1:0] remainder,
    output logic                div_by_zero,
    output logic                overflow
);

    localparam int              CW   = cnt_bits(N_BITS_A);
    localparam logic [CW-1:0]   LAST = CW'(N_BITS_A - 1);

    div_state_t          state;
    logic [CW-1:0]       step_cnt;
    logic                sa;
    logic                sb;
    logic                b_zero;
    logic                ovf;
    logic [N_BITS_A-1:0] dividend_sr;   // |a| shifting out, quotient bits shifting in
    logic [N_BITS_B-1:0] b_mag;
    logic [N_BITS_B:0]   prem;          // partial remainder

    // Operand magnitudes; |most negative| still fits in the unsigned width.
    logic [N_BITS_A-1:0] a_abs;
    logic [N_BITS_B-1:0] b_abs;
    logic                a_is_min;
    logic                b_is_neg1;

    assign a_abs     = a[N_BITS_A-1] ? (~a + 1'b1) : a;
    assign b_abs     = b[N_BITS_B-1] ? (~b + 1'b1) : b;
    assign a_is_min  = (a == {1'b1, {(N_BITS_A-1){1'b0}}});
    assign b_is_neg1 = &b;

    // One restoring step. prem < |b| <= 2^(N_BITS_B-1) always holds between
    // steps, so the shifted value fits in N_BITS_B+1 bits; one extra bit on
    // the trial difference carries its sign.
    logic [N_BITS_B:0]   shifted;
    logic [N_BITS_B+1:0] trial;
    logic                keep;

    assign shifted = {prem[N_BITS_B-1:0], dividend_sr[N_BITS_A-1]};
    assign trial   = {1'b0, shifted} - {2'b00, b_mag};
    assign keep    = ~trial[N_BITS_B+1];

    logic [N_BITS_A-1:0] fix_q;
    logic [N_BITS_B-1:0] fix_r;
    logic                fix_dz;
    logic                fix_ovf;

    div_sign_fix #(
        .N_BITS_A (N_BITS_A),
        .N_BITS_B (N_BITS_B)
    ) u_sign_fix (
        .q_mag       (dividend_sr),
        .r_mag       (prem[N_BITS_B-1:0]),
        .sa          (sa),
        .sb          (sb),
        .b_zero      (b_zero),
        .ovf         (ovf),
        .quotient    (fix_q),
        .remainder   (fix_r),
        .div_by_zero (fix_dz),
        .overflow    (fix_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            step_cnt    <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            b_zero      <= 1'b0;
            ovf         <= 1'b0;
            dividend_sr <= '0;
            b_mag       <= '0;
            prem        <= '0;
            busy        <= 1'b0;
            data_ready  <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_ready <= 1'b0;
                    if (start) begin
                        sa          <= a[N_BITS_A-1];
                        sb          <= b[N_BITS_B-1];
                        b_zero      <= (b == '0);
                        ovf         <= a_is_min & b_is_neg1;
                        dividend_sr <= a_abs;
                        b_mag       <= b_abs;
                        prem        <= '0;
                        step_cnt    <= '0;
                        busy        <= 1'b1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    prem        <= keep ? trial[N_BITS_B:0] : shifted;
                    dividend_sr <= {dividend_sr[N_BITS_A-2:0], keep};
                    step_cnt    <= step_cnt + 1'b1;
                    if (step_cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= fix_q;
                    remainder   <= fix_r;
                    div_by_zero <= fix_dz;
                    overflow    <= fix_ovf;
                    data_ready  <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_div.sv
// Directed self-checking bench for serial_div (8/8) with a reduced operand sweep.
// Latency: checks the N+1 edge result timing and one-cycle data_ready pulse.
// Backpressure: checks that start while busy is ignored and start during data_ready is taken.
module tb_serial_div;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic       busy;
    logic       data_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    serial_div #(
        .N_BITS_A (8),
        .N_BITS_B (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .start       (start),
        .busy        (busy),
        .data_ready  (data_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input int eq, input int er,
                             input logic edz, input logic eov);
        logic [7:0] q8;
        logic [7:0] r8;
        q8 = 8'(eq);
        r8 = 8'(er);
        check({tag, ".q"},   {24'b0, quotient},    {24'b0, q8});
        check({tag, ".r"},   {24'b0, remainder},   {24'b0, r8});
        check({tag, ".dz"},  {31'b0, div_by_zero}, {31'b0, edz});
        check({tag, ".ovf"}, {31'b0, overflow},    {31'b0, eov});
    endtask

    // Called at a negedge; start is seen by the following rising edge.
    task automatic launch(input int av, input int bv);
        a     = 8'(av);
        b     = 8'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until data_ready is seen, bounded.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (data_ready !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input int av, input int bv);
        int cyc;
        launch(av, bv);
        wait_ready(cyc);
        check({tag, ".lat"}, 32'(cyc), 32'd9);
    endtask

    // Reference: truncating division with the zero-divisor and overflow rules.
    task automatic model(input int av, input int bv, output int q, output int r,
                         output logic dz, output logic ov);
        dz = 1'b0;
        ov = 1'b0;
        if (bv == 0) begin
            q  = 0;
            r  = av;
            dz = 1'b1;
        end else if (av == -128 && bv == -1) begin
            q  = -128;
            r  = 0;
            ov = 1'b1;
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endtask

    int b_list [19] = '{-128, -127, -100, -64, -7, -3, -2, -1, 0, 1, 2, 3, 5, 7, 13, 64, 100, 126, 127};

    initial begin
        int cyc;
        int mq;
        int mr;
        logic mdz;
        logic mov;
        logic [17:0] exp_pk;

        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.busy", {31'b0, busy},       32'd0);
        check("rst.dr",   {31'b0, data_ready}, 32'd0);
        check_res("rst", 0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Basic op and timing: pulse exactly after edge k+9, one cycle wide
        launch(100, 7);
        check("p100_7.busy", {31'b0, busy}, 32'd1);
        wait_ready(cyc);
        check("p100_7.lat", 32'(cyc), 32'd9);
        check("p100_7.busy_end", {31'b0, busy}, 32'd0);
        check_res("p100_7", 14, 2, 1'b0, 1'b0);
        @(negedge clk);
        check("p100_7.pulse", {31'b0, data_ready}, 32'd0);
        check_res("p100_7.hold", 14, 2, 1'b0, 1'b0);

        // Sign cases
        run_op("m100_7", -100, 7);
        check_res("m100_7", -14, -2, 1'b0, 1'b0);
        run_op("p100_m7", 100, -7);
        check_res("p100_m7", -14, 2, 1'b0, 1'b0);
        run_op("m100_m7", -100, -7);
        check_res("m100_m7", 14, -2, 1'b0, 1'b0);

        // Boundaries
        run_op("m128_m1", -128, -1);
        check_res("m128_m1", -128, 0, 1'b0, 1'b1);
        run_op("p5_0", 5, 0);
        check_res("p5_0", 0, 5, 1'b1, 1'b0);
        run_op("m128_1", -128, 1);
        check_res("m128_1", -128, 0, 1'b0, 1'b0);
        run_op("m128_0", -128, 0);
        check_res("m128_0", 0, -128, 1'b1, 1'b0);
        run_op("p7_m128", 7, -128);
        check_res("p7_m128", 0, 7, 1'b0, 1'b0);

        // Start while busy is ignored
        @(negedge clk);
        launch(100, 7);
        repeat (3) @(negedge clk);
        a     = 8'd3;
        b     = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign.busy", {31'b0, busy}, 32'd1);
        wait_ready(cyc);
        check("ign.lat", 32'(cyc), 32'd5);
        check_res("ign", 14, 2, 1'b0, 1'b0);

        // Start during the data_ready cycle is accepted
        launch(-100, 7);
        check("b2b.busy", {31'b0, busy}, 32'd1);
        wait_ready(cyc);
        check("b2b.lat", 32'(cyc), 32'd9);
        check_res("b2b", -14, -2, 1'b0, 1'b0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        launch(100, 7);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("arst.busy", {31'b0, busy},       32'd0);
        check("arst.dr",   {31'b0, data_ready}, 32'd0);
        check_res("arst", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("p50_6", 50, 6);
        check_res("p50_6", 8, 2, 1'b0, 1'b0);

        // Reduced operand sweep against the reference model
        for (int ai = -128; ai <= 127; ai += 5) begin
            foreach (b_list[j]) begin
                run_op($sformatf("sw a=%0d b=%0d", ai, b_list[j]), ai, b_list[j]);
                model(ai, b_list[j], mq, mr, mdz, mov);
                exp_pk = {8'(mq), 8'(mr), mdz, mov};
                check($sformatf("sw a=%0d b=%0d", ai, b_list[j]),
                      {14'b0, quotient, remainder, div_by_zero, overflow},
                      {14'b0, exp_pk});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
